// File: rtl/ahb_arbiter_nm.sv
// ahb_arbiter_nm
//   AHB bus arbiter for NO_OF_MASTERS masters. Grants the shared address/control
//   path by fixed priority (ARB_MODE=0, index 0 highest) or round-robin
//   (ARB_MODE=1). It holds the grant across locked sequences and masks masters
//   that have been SPLIT until their slave signals completion on HSPLIT.
//
// Ports
//   i_hclk        clock, all state updates on the rising edge
//   i_hreset      synchronous active-high reset
//   i_hbusreq     per-master bus request
//   i_hlock       per-master locked-transfer request
//   i_hsplit      split-completion pulses, ORed from all slaves
//   i_hready      transfer complete from the selected slave
//   i_hresp       slave response: OKAY=0, ERROR=1, RETRY=2, SPLIT=3
//   o_hgrant      one-hot grant, registered
//   o_hmaster     master owning the current address phase, registered
//   o_hmastlock   current address phase is locked, registered

module ahb_arbiter_nm #(
  parameter int NO_OF_MASTERS  = 4,
  parameter int ARB_MODE       = 0,
  parameter int DEFAULT_MASTER = 0,
  parameter int MW             = $clog2(NO_OF_MASTERS)
) (
  input  logic                     i_hclk,
  input  logic                     i_hreset,
  input  logic [NO_OF_MASTERS-1:0] i_hbusreq,
  input  logic [NO_OF_MASTERS-1:0] i_hlock,
  input  logic [NO_OF_MASTERS-1:0] i_hsplit,
  input  logic                     i_hready,
  input  logic [1:0]               i_hresp,
  output logic [NO_OF_MASTERS-1:0] o_hgrant,
  output logic [MW-1:0]            o_hmaster,
  output logic                     o_hmastlock
);

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'd0,
    HRESP_ERROR = 2'd1,
    HRESP_RETRY = 2'd2,
    HRESP_SPLIT = 2'd3
  } hresp_t;

  localparam logic [MW-1:0]            DEF_IDX    = MW'(DEFAULT_MASTER);
  localparam logic [NO_OF_MASTERS-1:0] DEF_ONEHOT = NO_OF_MASTERS'(1) << DEFAULT_MASTER;

  // registered state
  logic [NO_OF_MASTERS-1:0] r_hgrant;
  logic [MW-1:0]            r_hmaster;
  logic                     r_hmastlock;
  logic [NO_OF_MASTERS-1:0] r_split_mask;
  logic [MW-1:0]            r_data_master;
  logic [MW-1:0]            r_rr_ptr;

  // combinational
  logic [MW-1:0]            w_gnt_idx;
  logic [NO_OF_MASTERS-1:0] w_elig;
  logic [MW-1:0]            w_fx_win;
  logic                     w_fx_found;
  logic [MW-1:0]            w_rr_win;
  logic                     w_rr_found;
  logic [MW-1:0]            w_rr_idx;
  logic [MW-1:0]            w_win;
  logic                     w_found;
  logic                     w_lock_hold;
  logic                     w_split_evt;
  logic                     w_split_set;
  logic                     w_lock_split;
  logic [NO_OF_MASTERS-1:0] w_split_vec;
  logic [NO_OF_MASTERS-1:0] w_split_mask_nxt;
  logic [NO_OF_MASTERS-1:0] w_grant_nxt;
  logic [MW-1:0]            w_rr_nxt;

  // Index of the one-hot grant (OR of the indices of set bits).
  always_comb begin
    w_gnt_idx = '0;
    for (int i = 0; i < NO_OF_MASTERS; i++) begin
      if (r_hgrant[i]) begin
        w_gnt_idx = w_gnt_idx | MW'(i);
      end
    end
  end

  assign w_elig = i_hbusreq & ~r_split_mask;

  // Fixed priority: scan downward so the lowest eligible index is the last write.
  always_comb begin
    w_fx_win   = DEF_IDX;
    w_fx_found = 1'b0;
    for (int i = NO_OF_MASTERS - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_fx_win   = MW'(i);
        w_fx_found = 1'b1;
      end
    end
  end

  // Round-robin: first eligible index starting one past the last winner.
  always_comb begin
    w_rr_win   = DEF_IDX;
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    for (int k = 1; k <= NO_OF_MASTERS; k++) begin
      w_rr_idx = MW'((int'(r_rr_ptr) + k) % NO_OF_MASTERS);
      if (!w_rr_found && w_elig[w_rr_idx]) begin
        w_rr_win   = w_rr_idx;
        w_rr_found = 1'b1;
      end
    end
  end

  assign w_win   = (ARB_MODE == 1) ? w_rr_win   : w_fx_win;
  assign w_found = (ARB_MODE == 1) ? w_rr_found : w_fx_found;

  // A master that is still split cannot hold the bus with HLOCK.
  assign w_lock_hold = i_hlock[w_gnt_idx] && !r_split_mask[w_gnt_idx];

  assign w_split_evt = i_hready && (hresp_t'(i_hresp) == HRESP_SPLIT);
  // The default master is never masked: it must always be able to own the bus.
  assign w_split_set = w_split_evt && (r_data_master != DEF_IDX);
  // A locked owner that just got SPLIT gives the bus up to the default master
  // immediately, instead of riding its lock for one more phase.
  assign w_lock_split = w_split_evt && w_lock_hold && (r_data_master == w_gnt_idx);

  assign w_split_vec      = w_split_set ? (NO_OF_MASTERS'(1) << r_data_master) : '0;
  // Clear is applied after set so a coincident HSPLIT wins.
  assign w_split_mask_nxt = (r_split_mask | w_split_vec) & ~i_hsplit;

  // Next grant; the arbitration above sees the mask from before this edge.
  always_comb begin
    w_grant_nxt = DEF_ONEHOT;
    w_rr_nxt    = r_rr_ptr;
    if (w_lock_split) begin
      w_grant_nxt = DEF_ONEHOT;
    end else if (w_lock_hold) begin
      w_grant_nxt = r_hgrant;
    end else if (w_found) begin
      w_grant_nxt = NO_OF_MASTERS'(1) << w_win;
      w_rr_nxt    = w_win;
    end
  end

  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      r_hgrant      <= DEF_ONEHOT;
      r_hmaster     <= DEF_IDX;
      r_hmastlock   <= 1'b0;
      r_split_mask  <= '0;
      r_data_master <= DEF_IDX;
      r_rr_ptr      <= DEF_IDX;
    end else begin
      r_split_mask <= w_split_mask_nxt;
      if (i_hready) begin
        r_data_master <= r_hmaster;
        r_hmaster     <= w_gnt_idx;
        r_hmastlock   <= i_hlock[w_gnt_idx];
        r_hgrant      <= w_grant_nxt;
        r_rr_ptr      <= w_rr_nxt;
      end
    end
  end

  assign o_hgrant    = r_hgrant;
  assign o_hmaster   = r_hmaster;
  assign o_hmastlock = r_hmastlock;

endmodule
